msx_mouse_reader: RTL and testbench
===================================

MSX_MOUSE_READER -- requirements
Module: msx_mouse_reader

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 64; it is the number of clk_sys cycles from each strobe toggle to the nibble sample.
REQ-002 SHALL have parameter GUARD_CYCLES, default 131072; it is the idle time after reset before the first read, and must exceed the responder's 100000-cycle nibble timeout.
REQ-003 SHALL have port clk_sys, input, 1 bit: system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit: request one 4-nibble read; it is sampled only while ready=1.
REQ-006 SHALL have port joy_in, input, 6 bits: MSX port lines. [3:0] is the data nibble, true level. [5:4] are the buttons, active-low.
REQ-007 SHALL have port stra, output, 1 bit: strobe (pin 8) driven to the mouse responder.
REQ-008 SHALL have port dx, output, 8 bits: last X delta, two's complement, exactly as received.
REQ-009 SHALL have port dy, output, 8 bits: last Y delta, two's complement, exactly as received.
REQ-010 SHALL have port btn, output, 2 bits: active-high buttons, equal to ~joy_in[5:4], captured with the 4th nibble.
REQ-011 SHALL have port valid, output, 1 bit: one-cycle pulse when dx, dy and btn have updated.
REQ-012 SHALL have port ready, output, 1 bit: high when a start will be accepted.

Function
REQ-013 SHALL implement states GUARD, IDLE, WAIT and DONE.
REQ-014 SHALL behave in GUARD as follows: stra is held at 0 and the guard counter counts GUARD_CYCLES; the state then moves to IDLE.
REQ-015 SHALL drive ready=1 only in IDLE; start in any other state SHALL be ignored and SHALL NOT be queued.
REQ-016 SHALL, on the edge E0 that samples start=1 in IDLE, toggle stra, set the nibble index to 0, load the settle counter and enter WAIT.
REQ-017 SHALL sample nibble k at edge E0+(k+1)*SETTLE_CYCLES for k=0..3; at the sample edges for k=0..2, stra SHALL also toggle.
REQ-018 SHALL assemble the nibbles as: nibble0 -> dx[7:4], nibble1 -> dx[3:0], nibble2 -> dy[7:4], nibble3 -> dy[3:0].
REQ-019 SHALL write dx, dy and btn only at the k=3 sample edge, enter DONE, and assert valid for exactly one cycle; the state SHALL then return to IDLE.
REQ-020 SHALL make the latency from the start sample edge to the valid-high cycle exactly 4*SETTLE_CYCLES+1 cycles.
REQ-021 SHALL leave stra at its pre-read level after a complete read, because the read makes 4 toggles in total.
REQ-022 SHALL make each read consist of exactly 4 edges, so the responder's state wraps 3->0 and stays aligned.
REQ-023 SHALL hold dx, dy and btn between reads; the next start SHALL NOT clear them.
REQ-024 SHALL keep the settle counter at ceil(log2(SETTLE_CYCLES+1)) bits with no wrap-around; SETTLE_CYCLES=1 is legal and gives one cycle per nibble.
REQ-025 SHALL keep the guard counter at ceil(log2(GUARD_CYCLES+1)) bits; it SHALL saturate and SHALL NOT wrap.
REQ-026 SHALL reject, as a static check, any combination with 4*SETTLE_CYCLES >= 100000.
REQ-027 SHALL sample joy_in directly with no synchronizer, because the responder shares clk_sys.

Reset
REQ-028 SHALL set, while reset=1: state=GUARD, stra=0, dx=0, dy=0, btn=0, valid=0, ready=0, guard counter=0, settle counter=0, nibble index=0.
REQ-029 SHALL handle reset during WAIT as follows: the partial read is discarded, stra goes to 0, and no valid is produced; the guard period lets the responder time out to state 0 before the next read.
REQ-030 SHALL treat reset and start in the same cycle as reset only.

Structure
REQ-031 SHALL place the following in shared package msx_joy_pkg: the state enum, NIBBLES_PER_READ=4, RESPONDER_TIMEOUT=100000, and the default SETTLE and GUARD values.
REQ-032 SHALL be a single module with no sub-module, because the FSM and two counters do not justify a split.

Verification
REQ-033 SHALL cover a basic read. Stimulus: responder BFM with dx=0x12, dy=0xF3 (-13), buttons pressed joy_in[5:4]=2'b00, and start one cycle after ready. Required: stra makes 4 edges, valid pulses once at E0+257 with SETTLE=64, and the outputs are dx=0x12, dy=0xF3, btn=2'b11.
REQ-034 SHALL cover ignored start. Stimulus: start held high for 300 cycles. Required: exactly one read occurs, followed by exactly one further read after ready returns; start is ignored while busy.
REQ-035 SHALL cover reset mid-read. Stimulus: reset after nibble 1. Required: stra=0, no valid, ready stays low for GUARD_CYCLES; then a read of dx=0x7F, dy=0x80 returns exactly those values, showing the responder resynchronised.
REQ-036 SHALL cover back-to-back reads. Stimulus: 10 consecutive reads with random deltas. Required: all values match, and stra ends each read at its starting level.
REQ-037 SHALL cover the minimum settle setting. Stimulus: SETTLE_CYCLES=1 with dx=0x00, dy=0xFF. Required: valid at E0+5 and the outputs are correct.
REQ-038 SHALL cover start after reset. Stimulus: start during GUARD. Required: ready=0, stra is unchanged, and no valid is produced.

Source files
------------

// File: rtl/msx_joy_pkg.sv
// Shared types and constants for the MSX joystick-port mouse reader.
// The state encoding and protocol constants are used by the reader RTL.
package msx_joy_pkg;

    localparam int NIBBLES_PER_READ      = 4;
    localparam int RESPONDER_TIMEOUT     = 100000;
    localparam int SETTLE_CYCLES_DEFAULT = 64;
    localparam int GUARD_CYCLES_DEFAULT  = 131072;

    typedef enum logic [1:0] {
        ST_GUARD = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_e;

endpackage

// File: rtl/msx_mouse_reader.sv
// MSX mouse reader: toggles the strobe line four times per read and assembles
// the four returned nibbles into signed X/Y deltas plus the button state.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// ST_GUARD | after reset; strobe low, wait out the responder's nibble timeout
// ST_IDLE  | ready for a start request
// ST_WAIT  | strobe toggled, settle counter running toward the next sample
// ST_DONE  | deltas and buttons updated, one-cycle valid
module msx_mouse_reader
    import msx_joy_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT,
    parameter int GUARD_CYCLES  = GUARD_CYCLES_DEFAULT
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] joy_in,
    output logic       stra,
    output logic [7:0] dx,
    output logic [7:0] dy,
    output logic [1:0] btn,
    output logic       valid,
    output logic       ready
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int GW = $clog2(GUARD_CYCLES + 1);

    // A whole read must finish before the responder gives up and resets its nibble index.
    if (4 * SETTLE_CYCLES >= RESPONDER_TIMEOUT) begin : g_settle_too_long
        $error("msx_mouse_reader: 4*SETTLE_CYCLES must be below RESPONDER_TIMEOUT");
    end
    if (SETTLE_CYCLES < 1) begin : g_settle_too_short
        $error("msx_mouse_reader: SETTLE_CYCLES must be at least 1");
    end

    rd_state_e       state_q, state_d;
    logic [GW-1:0]   guard_q, guard_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [1:0]      idx_q, idx_d;
    logic            stra_q, stra_d;
    logic [11:0]     acc_q, acc_d;
    logic [7:0]      dx_q, dx_d;
    logic [7:0]      dy_q, dy_d;
    logic [1:0]      btn_q, btn_d;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= ST_GUARD;
            guard_q  <= '0;
            settle_q <= '0;
            idx_q    <= '0;
            stra_q   <= 1'b0;
            acc_q    <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            btn_q    <= '0;
        end else begin
            state_q  <= state_d;
            guard_q  <= guard_d;
            settle_q <= settle_d;
            idx_q    <= idx_d;
            stra_q   <= stra_d;
            acc_q    <= acc_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            btn_q    <= btn_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        guard_d  = guard_q;
        settle_d = settle_q;
        idx_d    = idx_q;
        stra_d   = stra_q;
        acc_d    = acc_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        btn_d    = btn_q;

        unique case (state_q)
            ST_GUARD: begin
                stra_d = 1'b0;
                if (guard_q != GW'(GUARD_CYCLES)) begin
                    guard_d = guard_q + GW'(1);
                end
                if (guard_q >= GW'(GUARD_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (start) begin
                    stra_d   = ~stra_q;
                    idx_d    = '0;
                    settle_d = SW'(SETTLE_CYCLES - 1);
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (settle_q == '0) begin
                    acc_d = {acc_q[7:0], joy_in[3:0]};
                    // Last nibble: no toggle, so four edges per read keep the responder aligned.
                    if (idx_q == 2'(NIBBLES_PER_READ - 1)) begin
                        dx_d    = acc_q[11:4];
                        dy_d    = {acc_q[3:0], joy_in[3:0]};
                        btn_d   = ~joy_in[5:4];
                        state_d = ST_DONE;
                    end else begin
                        stra_d   = ~stra_q;
                        idx_d    = idx_q + 2'd1;
                        settle_d = SW'(SETTLE_CYCLES - 1);
                    end
                end else begin
                    settle_d = settle_q - SW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_GUARD;
            end
        endcase
    end

    assign stra  = stra_q;
    assign dx    = dx_q;
    assign dy    = dy_q;
    assign btn   = btn_q;
    assign valid = (state_q == ST_DONE);
    assign ready = (state_q == ST_IDLE);

endmodule

// File: tb/tb_msx_mouse_reader.sv
// Directed bench for msx_mouse_reader with a behavioural mouse responder per DUT.
// Main DUT uses SETTLE=64 with a shortened guard/timeout pair; a second DUT uses SETTLE=1.
module tb_msx_mouse_reader;

    localparam int S_A  = 64;
    localparam int G_A  = 1500;
    localparam int TO_A = 1000;   // responder timeout in cycles, below G_A
    localparam int S_M  = 1;
    localparam int G_M  = 20;
    localparam int TO_M = 10;

    int errors = 0;
    int checks = 0;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       start;
    logic       sel_min;
    logic [7:0] bfm_dx, bfm_dy;
    logic [1:0] bfm_btn_n;

    logic       start_a, start_m;
    logic [5:0] joy_a, joy_m;
    logic [3:0] nib_a, nib_m;
    logic [1:0] ptr_a, ptr_m;
    time        last_a, last_m;
    logic       stra_a, stra_m, valid_a, valid_m, ready_a, ready_m;
    logic [7:0] dx_a, dy_a, dx_m, dy_m;
    logic [1:0] btn_a, btn_m;

    logic       o_stra, o_valid, o_ready;
    logic [7:0] o_dx, o_dy;
    logic [1:0] o_btn;

    always #5 clk_sys = ~clk_sys;

    assign start_a = start & ~sel_min;
    assign start_m = start & sel_min;
    assign joy_a   = {bfm_btn_n, nib_a};
    assign joy_m   = {bfm_btn_n, nib_m};
    assign o_stra  = sel_min ? stra_m  : stra_a;
    assign o_valid = sel_min ? valid_m : valid_a;
    assign o_ready = sel_min ? ready_m : ready_a;
    assign o_dx    = sel_min ? dx_m    : dx_a;
    assign o_dy    = sel_min ? dy_m    : dy_a;
    assign o_btn   = sel_min ? btn_m   : btn_a;

    msx_mouse_reader #(.SETTLE_CYCLES(S_A), .GUARD_CYCLES(G_A)) u_dut_a (
        .clk_sys(clk_sys), .reset(reset), .start(start_a), .joy_in(joy_a),
        .stra(stra_a), .dx(dx_a), .dy(dy_a), .btn(btn_a), .valid(valid_a), .ready(ready_a)
    );

    msx_mouse_reader #(.SETTLE_CYCLES(S_M), .GUARD_CYCLES(G_M)) u_dut_m (
        .clk_sys(clk_sys), .reset(reset), .start(start_m), .joy_in(joy_m),
        .stra(stra_m), .dx(dx_m), .dy(dy_m), .btn(btn_m), .valid(valid_m), .ready(ready_m)
    );

    function automatic logic [3:0] nib_of(input logic [1:0] p);
        case (p)
            2'd0:    return bfm_dx[7:4];
            2'd1:    return bfm_dx[3:0];
            2'd2:    return bfm_dy[7:4];
            default: return bfm_dy[3:0];
        endcase
    endfunction

    // Responder: every strobe edge presents the next nibble; a long gap restarts at nibble 0.
    initial begin
        ptr_a = 2'd0; nib_a = 4'd0; last_a = 0;
        ptr_m = 2'd0; nib_m = 4'd0; last_m = 0;
    end

    always @(stra_a) begin
        if ($time - last_a > TO_A * 10) ptr_a = 2'd0;
        nib_a  = nib_of(ptr_a);
        ptr_a  = ptr_a + 2'd1;
        last_a = $time;
    end

    always @(stra_m) begin
        if ($time - last_m > TO_M * 10) ptr_m = 2'd0;
        nib_m  = nib_of(ptr_m);
        ptr_m  = ptr_m + 2'd1;
        last_m = $time;
    end

    task automatic wait_ready(input int budget);
        int n = 0;
        while (o_ready !== 1'b1 && n < budget) begin
            @(negedge clk_sys);
            n++;
        end
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_ready: ready=%b required 1 within %0d cycles", o_ready, budget);
        end
    endtask

    // One full read with timing, edge count and data checks.
    task automatic do_read(input string name, input logic [7:0] xd, input logic [7:0] yd,
                           input logic [1:0] bn, input int s);
        int   vcnt = 0, vat = 0, tog = 0;
        logic stra0, prev;
        bfm_dx = xd; bfm_dy = yd; bfm_btn_n = bn;
        wait_ready(600);
        stra0 = o_stra;
        prev  = o_stra;
        start = 1'b1;
        for (int n = 1; n <= 4 * s + 20; n++) begin
            @(negedge clk_sys);
            if (n == 1) start = 1'b0;
            if (o_stra !== prev) tog++;
            prev = o_stra;
            if (o_valid === 1'b1) begin
                vcnt++;
                if (vcnt == 1) vat = n;
            end
        end
        checks += 7;
        if (vcnt != 1) begin errors++; $display("FAIL %s valid_count: got %0d required 1", name, vcnt); end
        if (vat != 4 * s + 1) begin errors++; $display("FAIL %s valid_latency: got %0d required %0d", name, vat, 4 * s + 1); end
        if (tog != 4) begin errors++; $display("FAIL %s stra_edges: got %0d required 4", name, tog); end
        if (o_stra !== stra0) begin errors++; $display("FAIL %s stra_level: got %b required %b", name, o_stra, stra0); end
        if (o_dx !== xd) begin errors++; $display("FAIL %s dx: got %h required %h", name, o_dx, xd); end
        if (o_dy !== yd) begin errors++; $display("FAIL %s dy: got %h required %h", name, o_dy, yd); end
        if (o_btn !== ~bn) begin errors++; $display("FAIL %s btn: got %b required %b", name, o_btn, ~bn); end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; sel_min = 1'b0;
        bfm_dx = 8'h00; bfm_dy = 8'h00; bfm_btn_n = 2'b11;
        repeat (3) @(negedge clk_sys);
        checks += 6;
        if (o_stra !== 1'b0)  begin errors++; $display("FAIL reset_stra: got %b required 0", o_stra); end
        if (o_dx !== 8'h00)   begin errors++; $display("FAIL reset_dx: got %h required 00", o_dx); end
        if (o_dy !== 8'h00)   begin errors++; $display("FAIL reset_dy: got %h required 00", o_dy); end
        if (o_btn !== 2'b00)  begin errors++; $display("FAIL reset_btn: got %b required 00", o_btn); end
        if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", o_valid); end
        if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b required 0", o_ready); end
    endtask

    task automatic test_start_in_guard();
        int bad = 0, rdy_at = 0, late = 0;
        reset = 1'b0;
        for (int n = 1; n <= G_A + 50 && rdy_at == 0; n++) begin
            @(negedge clk_sys);
            if (n == 10) start = 1'b1;
            if (n == 40) start = 1'b0;
            if (o_ready === 1'b1) rdy_at = n;
            else if (o_stra !== 1'b0 || o_valid !== 1'b0) bad++;
        end
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_sys);
            if (o_stra !== 1'b0 || o_valid !== 1'b0 || o_ready !== 1'b1) late++;
        end
        checks += 3;
        if (bad != 0) begin errors++; $display("FAIL guard_quiet: %0d cycles with stra/valid active, required 0", bad); end
        if (rdy_at != G_A) begin errors++; $display("FAIL guard_length: ready after %0d cycles required %0d", rdy_at, G_A); end
        if (late != 0) begin errors++; $display("FAIL guard_no_queue: %0d idle cycles disturbed, required 0", late); end
    endtask

    task automatic test_basic_read();
        do_read("basic", 8'h12, 8'hF3, 2'b00, S_A);
    endtask

    task automatic test_ignored_start();
        int   vcnt1 = 0, vcnt = 0, v1 = 0, v2 = 0, tog = 0;
        logic prev;
        bfm_dx = 8'hA5; bfm_dy = 8'h3C; bfm_btn_n = 2'b01;
        wait_ready(600);
        prev  = o_stra;
        start = 1'b1;
        for (int n = 1; n <= 600; n++) begin
            @(negedge clk_sys);
            if (n == 300) start = 1'b0;
            if (o_stra !== prev) tog++;
            prev = o_stra;
            if (o_valid === 1'b1) begin
                vcnt++;
                if (vcnt == 1) v1 = n;
                if (vcnt == 2) v2 = n;
                if (n <= 300) vcnt1++;
            end
        end
        checks += 6;
        if (vcnt1 != 1) begin errors++; $display("FAIL held_first_window: valids=%0d required 1", vcnt1); end
        if (vcnt != 2) begin errors++; $display("FAIL held_total_reads: valids=%0d required 2", vcnt); end
        if (v1 != 4 * S_A + 1) begin errors++; $display("FAIL held_first_valid: at %0d required %0d", v1, 4 * S_A + 1); end
        if (v2 != 8 * S_A + 3) begin errors++; $display("FAIL held_second_valid: at %0d required %0d", v2, 8 * S_A + 3); end
        if (tog != 8) begin errors++; $display("FAIL held_stra_edges: got %0d required 8", tog); end
        if (o_dx !== 8'hA5 || o_dy !== 8'h3C || o_btn !== 2'b10) begin
            errors++;
            $display("FAIL held_data: got %h/%h/%b required a5/3c/10", o_dx, o_dy, o_btn);
        end
    endtask

    task automatic test_reset_mid_read();
        int vcnt = 0, rdy_at = 0, bad = 0;
        bfm_dx = 8'h55; bfm_dy = 8'hAA; bfm_btn_n = 2'b11;
        wait_ready(600);
        start = 1'b1;
        for (int n = 1; n <= 2 * S_A + 10; n++) begin
            @(negedge clk_sys);
            if (n == 1) start = 1'b0;
            if (o_valid === 1'b1) vcnt++;
        end
        reset = 1'b1;
        @(negedge clk_sys);
        checks += 4;
        if (o_stra !== 1'b0)  begin errors++; $display("FAIL midreset_stra: got %b required 0", o_stra); end
        if (o_valid !== 1'b0 || vcnt != 0) begin errors++; $display("FAIL midreset_valid: valid=%b count=%0d required none", o_valid, vcnt); end
        if (o_ready !== 1'b0) begin errors++; $display("FAIL midreset_ready: got %b required 0", o_ready); end
        if (o_dx !== 8'h00)   begin errors++; $display("FAIL midreset_dx: got %h required 00", o_dx); end
        @(negedge clk_sys);
        reset = 1'b0;
        for (int n = 1; n <= G_A + 50 && rdy_at == 0; n++) begin
            @(negedge clk_sys);
            if (o_ready === 1'b1) rdy_at = n;
            else if (o_valid !== 1'b0 || o_stra !== 1'b0) bad++;
        end
        checks += 2;
        if (rdy_at != G_A) begin errors++; $display("FAIL midreset_guard: ready after %0d required %0d", rdy_at, G_A); end
        if (bad != 0) begin errors++; $display("FAIL midreset_quiet: %0d bad cycles required 0", bad); end
        do_read("resync", 8'h7F, 8'h80, 2'b10, S_A);
    endtask

    task automatic test_back_to_back();
        logic [7:0] x, y;
        logic [1:0] b;
        for (int i = 0; i < 10; i++) begin
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            b = 2'($urandom_range(0, 3));
            do_read($sformatf("b2b%0d", i), x, y, b, S_A);
        end
    endtask

    task automatic test_min_settle();
        sel_min = 1'b1;
        @(negedge clk_sys);
        do_read("min_settle", 8'h00, 8'hFF, 2'b01, S_M);
        do_read("min_settle2", 8'h9E, 8'h41, 2'b10, S_M);
        sel_min = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_start_in_guard();
        test_basic_read();
        test_ignored_start();
        test_reset_mid_read();
        test_back_to_back();
        test_min_settle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
